// File: rtl/gw2a_pll_pkg.sv
// Shared definitions for the GW2A rPLL run-time controller and the PLL wrapper:
// state encoding, default divider codes (27 MHz in, 120 MHz out), counter sizing.
package gw2a_pll_pkg;

    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_ASSERT = 3'd0;
    localparam state_t ST_WAIT   = 3'd1;
    localparam state_t ST_SETTLE = 3'd2;
    localparam state_t ST_LOCKED = 3'd3;
    localparam state_t ST_FAULT  = 3'd4;

    localparam int CODE_W = 6;

    // Raw rPLL pin encodings, passed straight to IDSEL/FBDSEL/ODSEL.
    localparam logic [CODE_W-1:0] IDSEL_DEFAULT  = 6'h37;
    localparam logic [CODE_W-1:0] FBDSEL_DEFAULT = 6'h18;
    localparam logic [CODE_W-1:0] ODSEL_DEFAULT  = 6'h3C;

    // One spare bit above the limit so a saturated counter can hold the limit itself.
    function automatic int cnt_width(input int limit);
        return $clog2(limit) + 1;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Two-stage synchroniser for asynchronous level signals into the clock domain.
module sync_ff #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/gw2a_rpll_ctrl.sv
// GW2A rPLL dynamic-divider controller: sequences PLL reset, qualifies lock,
// retries on timeout, relocks after lock loss and applies new divider codes on request.
module gw2a_rpll_ctrl
    import gw2a_pll_pkg::*;
#(
    parameter logic [5:0] IDSEL_INIT    = IDSEL_DEFAULT,
    parameter logic [5:0] FBDSEL_INIT   = FBDSEL_DEFAULT,
    parameter logic [5:0] ODSEL_INIT    = ODSEL_DEFAULT,
    parameter int         RESET_CYCLES  = 16,
    parameter int         SETTLE_CYCLES = 64,
    parameter int         LOCK_TIMEOUT  = 4096,
    parameter int         RETRIES       = 3
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [5:0] req_idsel,
    input  logic [5:0] req_fbdsel,
    input  logic [5:0] req_odsel,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [5:0] pll_idsel,
    output logic [5:0] pll_fbdsel,
    output logic [5:0] pll_odsel,
    output logic       locked,
    output logic       busy,
    output logic       fault
);

    localparam int RST_W = cnt_width(RESET_CYCLES);
    localparam int SET_W = cnt_width(SETTLE_CYCLES);
    localparam int TO_W  = cnt_width(LOCK_TIMEOUT);
    localparam int ATT_W = cnt_width(RETRIES);

    localparam logic [RST_W-1:0] RST_LIM = RST_W'(RESET_CYCLES);
    localparam logic [SET_W-1:0] SET_LIM = SET_W'(SETTLE_CYCLES);
    localparam logic [TO_W-1:0]  TO_LIM  = TO_W'(LOCK_TIMEOUT);
    localparam logic [ATT_W-1:0] ATT_LIM = ATT_W'(RETRIES);

    state_t state_reg, state_next;

    logic [RST_W-1:0] rst_cnt_reg, rst_cnt_next, rst_inc;
    logic [SET_W-1:0] set_cnt_reg, set_cnt_next, set_inc;
    logic [TO_W-1:0]  to_cnt_reg,  to_cnt_next,  to_inc;
    logic [ATT_W-1:0] att_cnt_reg, att_cnt_next, att_inc;

    logic [5:0] idsel_reg, fbdsel_reg, odsel_reg;

    logic lock_s;
    logic accept;
    logic attempt_fail;
    logic load_codes;

    sync_ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (pll_lock),
        .q       (lock_s)
    );

    assign accept = req_valid && req_ready;

    // Saturating increments: counters stick at their limit instead of wrapping.
    assign rst_inc = (rst_cnt_reg == RST_LIM) ? rst_cnt_reg : rst_cnt_reg + RST_W'(1);
    assign set_inc = (set_cnt_reg == SET_LIM) ? set_cnt_reg : set_cnt_reg + SET_W'(1);
    assign to_inc  = (to_cnt_reg  == TO_LIM)  ? to_cnt_reg  : to_cnt_reg  + TO_W'(1);
    assign att_inc = (att_cnt_reg == ATT_LIM) ? att_cnt_reg : att_cnt_reg + ATT_W'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_ASSERT;
            rst_cnt_reg <= '0;
            set_cnt_reg <= '0;
            to_cnt_reg  <= '0;
            att_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            rst_cnt_reg <= rst_cnt_next;
            set_cnt_reg <= set_cnt_next;
            to_cnt_reg  <= to_cnt_next;
            att_cnt_reg <= att_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        rst_cnt_next = rst_cnt_reg;
        set_cnt_next = set_cnt_reg;
        to_cnt_next  = to_cnt_reg;
        att_cnt_next = att_cnt_reg;
        attempt_fail = 1'b0;
        load_codes   = 1'b0;

        case (state_reg)
            ST_ASSERT: begin
                rst_cnt_next = rst_inc;
                if (rst_inc == RST_LIM) begin
                    state_next   = ST_WAIT;
                    rst_cnt_next = '0;
                    to_cnt_next  = '0;
                    set_cnt_next = '0;
                end
            end
            ST_WAIT: begin
                to_cnt_next = to_inc;
                if (lock_s) begin
                    set_cnt_next = SET_W'(1);
                    state_next   = (SET_W'(1) == SET_LIM) ? ST_LOCKED : ST_SETTLE;
                end else if (to_inc == TO_LIM) begin
                    attempt_fail = 1'b1;
                end
            end
            ST_SETTLE: begin
                to_cnt_next = to_inc;
                if (lock_s) begin
                    set_cnt_next = set_inc;
                    // A lock that qualifies on the final allowed cycle still counts.
                    if (set_inc == SET_LIM) begin
                        state_next = ST_LOCKED;
                    end else if (to_inc == TO_LIM) begin
                        attempt_fail = 1'b1;
                    end
                end else begin
                    set_cnt_next = '0;
                    if (to_inc == TO_LIM) begin
                        attempt_fail = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_LOCKED: begin
                if (!lock_s) begin
                    state_next   = ST_ASSERT;
                    rst_cnt_next = '0;
                    att_cnt_next = '0;
                end
            end
            ST_FAULT: begin
                state_next = ST_FAULT;
            end
            default: begin
                state_next   = ST_ASSERT;
                rst_cnt_next = '0;
            end
        endcase

        if (attempt_fail) begin
            att_cnt_next = att_inc;
            rst_cnt_next = '0;
            state_next   = (att_inc < ATT_LIM) ? ST_ASSERT : ST_FAULT;
        end

        // A request overrides a coincident lock loss so ASSERT is entered only once.
        if (accept) begin
            state_next   = ST_ASSERT;
            rst_cnt_next = '0;
            att_cnt_next = '0;
            load_codes   = 1'b1;
        end
    end

    always_comb begin
        pll_reset = 1'b0;
        locked    = 1'b0;
        busy      = 1'b0;
        fault     = 1'b0;
        req_ready = 1'b0;
        case (state_reg)
            ST_ASSERT: begin
                pll_reset = 1'b1;
                busy      = 1'b1;
            end
            ST_WAIT, ST_SETTLE: begin
                busy = 1'b1;
            end
            ST_LOCKED: begin
                locked    = 1'b1;
                req_ready = 1'b1;
            end
            ST_FAULT: begin
                fault     = 1'b1;
                req_ready = 1'b1;
            end
            default: begin
                pll_reset = 1'b1;
                busy      = 1'b1;
            end
        endcase
    end

    // Codes change only on an accepted request; retries reuse them unchanged.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idsel_reg  <= IDSEL_INIT;
            fbdsel_reg <= FBDSEL_INIT;
            odsel_reg  <= ODSEL_INIT;
        end else if (load_codes) begin
            idsel_reg  <= req_idsel;
            fbdsel_reg <= req_fbdsel;
            odsel_reg  <= req_odsel;
        end
    end

    assign pll_idsel  = idsel_reg;
    assign pll_fbdsel = fbdsel_reg;
    assign pll_odsel  = odsel_reg;

endmodule

// File: tb/tb_gw2a_rpll_ctrl.sv
// Self-checking bench for gw2a_rpll_ctrl: a behavioural PLL drives pll_lock and the
// expected event timings and codes are derived arithmetically from the block's rules.
module tb_gw2a_rpll_ctrl;

    localparam logic [5:0] ID_INIT = 6'h37;
    localparam logic [5:0] FB_INIT = 6'h18;
    localparam logic [5:0] OD_INIT = 6'h3C;
    localparam int RST_CYC  = 16;
    localparam int SETTLE   = 64;
    localparam int TIMEOUT  = 4096;
    localparam int RETRY    = 3;
    localparam int SYNC_LAT = 2;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [5:0] req_idsel = '0, req_fbdsel = '0, req_odsel = '0;
    logic       pll_lock = 1'b0;
    logic       req_ready, pll_reset, locked, busy, fault;
    logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;

    int tests = 0;
    int failures = 0;

    // Reference model state: codes the PLL should currently be driven with.
    logic [17:0] exp_codes = {ID_INIT, FB_INIT, OD_INIT};
    logic [17:0] got_codes;
    assign got_codes = {pll_idsel, pll_fbdsel, pll_odsel};

    always #5 clock = ~clock;

    gw2a_rpll_ctrl #(
        .IDSEL_INIT    (ID_INIT),
        .FBDSEL_INIT   (FB_INIT),
        .ODSEL_INIT    (OD_INIT),
        .RESET_CYCLES  (RST_CYC),
        .SETTLE_CYCLES (SETTLE),
        .LOCK_TIMEOUT  (TIMEOUT),
        .RETRIES       (RETRY)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_idsel  (req_idsel),
        .req_fbdsel (req_fbdsel),
        .req_odsel  (req_odsel),
        .pll_lock   (pll_lock),
        .pll_reset  (pll_reset),
        .pll_idsel  (pll_idsel),
        .pll_fbdsel (pll_fbdsel),
        .pll_odsel  (pll_odsel),
        .locked     (locked),
        .busy       (busy),
        .fault      (fault)
    );

    // Model: from pll_lock rising, lock_s needs SYNC_LAT clocks, then SETTLE qualified clocks.
    function automatic int exp_lock_latency();
        return SYNC_LAT + SETTLE;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic count_high(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (pll_reset === 1'b1 && n < RST_CYC + 50);
    endtask

    task automatic count_low(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (pll_reset !== 1'b1 && fault !== 1'b1 && n < TIMEOUT + 50);
    endtask

    // Behavioural PLL locks d clocks after pll_reset falls; returns clocks until locked.
    task automatic settle_lock(input int d, output int k, output bit stray);
        stray = 1'b0;
        for (int i = 0; i < d; i++) begin
            step();
            if (pll_reset === 1'b1 || locked === 1'b1) stray = 1'b1;
        end
        pll_lock = 1'b1;
        k = 0;
        do begin
            step();
            k++;
            if (pll_reset === 1'b1) stray = 1'b1;
        end while (locked !== 1'b1 && k < SETTLE + SYNC_LAT + 50);
        $display("[TB] lock: pll delay %0d, locked after %0d clocks", d, k);
    endtask

    task automatic issue_request(input logic [5:0] id, input logic [5:0] fb, input logic [5:0] od);
        req_valid  = 1'b1;
        req_idsel  = id;
        req_fbdsel = fb;
        req_odsel  = od;
        step();
        req_valid = 1'b0;
        pll_lock  = 1'b0;
        exp_codes = {id, fb, od};
        $display("[TB] request: idsel=%h fbdsel=%h odsel=%h", id, fb, od);
    endtask

    task automatic pulse_train(output int pulses, output int hmin, output int hmax,
                               output int lmin, output int lmax);
        int h, l;
        pulses = 0;
        hmin = 1 << 30; hmax = -1; lmin = 1 << 30; lmax = -1;
        while (fault !== 1'b1 && pulses < RETRY + 2) begin
            count_high(h);
            count_low(l);
            pulses++;
            if (h < hmin) hmin = h;
            if (h > hmax) hmax = h;
            if (l < lmin) lmin = l;
            if (l > lmax) lmax = l;
        end
        $display("[TB] pulse train: %0d pulses, high %0d..%0d, low %0d..%0d", pulses, hmin, hmax, lmin, lmax);
    endtask

    task automatic test_reset();
        int n, k;
        bit stray;
        reset_n = 1'b0;
        pll_lock = 1'b0;
        repeat (3) step();
        tests++; if (pll_reset !== 1'b1) begin failures++; $display("FAIL rst_pll_reset: got %b want 1", pll_reset); end
        tests++; if ({locked, busy, fault, req_ready} !== 4'b0100) begin failures++; $display("FAIL rst_flags: got %b want 0100", {locked, busy, fault, req_ready}); end
        tests++; if (got_codes !== exp_codes) begin failures++; $display("FAIL rst_codes: got %h want %h", got_codes, exp_codes); end
        #3 reset_n = 1'b1;
        count_high(n);
        tests++; if (n !== RST_CYC) begin failures++; $display("FAIL rst_pulse_width: got %0d want %0d", n, RST_CYC); end
        tests++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_busy_wait: got %b want 1", busy); end
        settle_lock(100, k, stray);
        tests++; if (k !== exp_lock_latency()) begin failures++; $display("FAIL rst_lock_latency: got %0d want %0d", k, exp_lock_latency()); end
        tests++; if (stray !== 1'b0) begin failures++; $display("FAIL rst_stray_event: got %b want 0", stray); end
        tests++; if ({busy, req_ready, got_codes} !== {2'b01, exp_codes}) begin failures++; $display("FAIL rst_locked_state: got %b/%b/%h want 0/1/%h", busy, req_ready, got_codes, exp_codes); end
    endtask

    task automatic test_request();
        int n, k;
        bit stray;
        logic [17:0] rnd;
        for (int r = 0; r < 2; r++) begin
            rnd = (r == 0) ? {6'h3A, 6'h10, 6'h3E} : 18'($urandom);
            tests++; if (req_ready !== 1'b1) begin failures++; $display("FAIL req_ready_before: got %b want 1", req_ready); end
            issue_request(rnd[17:12], rnd[11:6], rnd[5:0]);
            tests++; if (got_codes !== exp_codes) begin failures++; $display("FAIL req_codes: got %h want %h", got_codes, exp_codes); end
            tests++; if ({pll_reset, locked, req_ready, busy} !== 4'b1001) begin failures++; $display("FAIL req_flags: got %b want 1001", {pll_reset, locked, req_ready, busy}); end
            count_high(n);
            tests++; if (n !== RST_CYC) begin failures++; $display("FAIL req_pulse_width: got %0d want %0d", n, RST_CYC); end
            settle_lock(int'($urandom_range(1, 600)), k, stray);
            tests++; if (k !== exp_lock_latency() || stray) begin failures++; $display("FAIL req_relock: got %0d stray %b want %0d stray 0", k, stray, exp_lock_latency()); end
            tests++; if (got_codes !== exp_codes) begin failures++; $display("FAIL req_codes_after: got %h want %h", got_codes, exp_codes); end
        end
    endtask

    task automatic test_glitch();
        int n, k, g;
        bit stray;
        logic [17:0] rnd;
        rnd = 18'($urandom);
        issue_request(rnd[17:12], rnd[11:6], rnd[5:0]);
        count_high(n);
        stray = 1'b0;
        for (int i = 0; i < int'($urandom_range(1, 400)); i++) begin
            step();
            if (pll_reset === 1'b1) stray = 1'b1;
        end
        g = (38 + SYNC_LAT) + int'($urandom_range(0, 4));
        pll_lock = 1'b1;
        for (int i = 0; i < g; i++) begin
            step();
            if (pll_reset === 1'b1 || locked === 1'b1) stray = 1'b1;
        end
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        k = 0;
        do begin
            step();
            k++;
            if (pll_reset === 1'b1) stray = 1'b1;
        end while (locked !== 1'b1 && k < SETTLE + SYNC_LAT + 50);
        $display("[TB] glitch at %0d clocks into lock, locked %0d clocks after recovery", g, k);
        tests++; if (k !== exp_lock_latency()) begin failures++; $display("FAIL glitch_relock: got %0d want %0d", k, exp_lock_latency()); end
        tests++; if (stray !== 1'b0) begin failures++; $display("FAIL glitch_stray_event: got %b want 0", stray); end
    endtask

    task automatic test_lock_loss();
        int n, k, p, hmin, hmax, lmin, lmax;
        bit stray;
        logic [17:0] rnd;
        pll_lock = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (locked === 1'b1 && n < 20);
        tests++; if (n !== SYNC_LAT + 1) begin failures++; $display("FAIL loss_latency: got %0d want %0d", n, SYNC_LAT + 1); end
        tests++; if (pll_reset !== 1'b1) begin failures++; $display("FAIL loss_reset_edge: got %b want 1", pll_reset); end
        tests++; if (got_codes !== exp_codes) begin failures++; $display("FAIL loss_codes: got %h want %h", got_codes, exp_codes); end
        count_high(n);
        tests++; if (n !== RST_CYC) begin failures++; $display("FAIL loss_pulse_width: got %0d want %0d", n, RST_CYC); end
        settle_lock(int'($urandom_range(1, 600)), k, stray);
        tests++; if (k !== exp_lock_latency() || stray) begin failures++; $display("FAIL loss_relock: got %0d stray %b want %0d stray 0", k, stray, exp_lock_latency()); end
        // One failed attempt before locking, then a lock loss must restore the full retry budget.
        rnd = 18'($urandom);
        issue_request(rnd[17:12], rnd[11:6], rnd[5:0]);
        count_high(n);
        count_low(n);
        tests++; if (n !== TIMEOUT || fault !== 1'b0) begin failures++; $display("FAIL loss_first_timeout: got %0d fault %b want %0d fault 0", n, fault, TIMEOUT); end
        count_high(n);
        settle_lock(int'($urandom_range(1, 600)), k, stray);
        tests++; if (k !== exp_lock_latency() || stray) begin failures++; $display("FAIL loss_retry_lock: got %0d stray %b want %0d stray 0", k, stray, exp_lock_latency()); end
        pll_lock = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (locked === 1'b1 && n < 20);
        pulse_train(p, hmin, hmax, lmin, lmax);
        tests++; if (p !== RETRY) begin failures++; $display("FAIL loss_att_reset_pulses: got %0d want %0d", p, RETRY); end
        tests++; if (fault !== 1'b1) begin failures++; $display("FAIL loss_fault: got %b want 1", fault); end
    endtask

    task automatic test_coincident();
        int n, k;
        bit stray;
        logic [17:0] rnd;
        rnd = 18'($urandom);
        issue_request(rnd[17:12], rnd[11:6], rnd[5:0]);
        count_high(n);
        settle_lock(int'($urandom_range(1, 600)), k, stray);
        pll_lock = 1'b0;
        repeat (SYNC_LAT) step();
        tests++; if ({locked, req_ready} !== 2'b11) begin failures++; $display("FAIL coin_still_locked: got %b want 11", {locked, req_ready}); end
        rnd = 18'($urandom);
        issue_request(rnd[17:12], rnd[11:6], rnd[5:0]);
        tests++; if (got_codes !== exp_codes) begin failures++; $display("FAIL coin_codes: got %h want %h", got_codes, exp_codes); end
        tests++; if ({pll_reset, locked} !== 2'b10) begin failures++; $display("FAIL coin_flags: got %b want 10", {pll_reset, locked}); end
        count_high(n);
        tests++; if (n !== RST_CYC) begin failures++; $display("FAIL coin_single_assert: got %0d want %0d", n, RST_CYC); end
        settle_lock(int'($urandom_range(1, 600)), k, stray);
        tests++; if (k !== exp_lock_latency() || stray) begin failures++; $display("FAIL coin_relock: got %0d stray %b want %0d stray 0", k, stray, exp_lock_latency()); end
    endtask

    task automatic test_timeout();
        int n, k, p, hmin, hmax, lmin, lmax;
        bit stray;
        logic [17:0] rnd;
        rnd = 18'($urandom);
        issue_request(rnd[17:12], rnd[11:6], rnd[5:0]);
        pulse_train(p, hmin, hmax, lmin, lmax);
        tests++; if (p !== RETRY) begin failures++; $display("FAIL to_pulse_count: got %0d want %0d", p, RETRY); end
        tests++; if (hmin !== RST_CYC || hmax !== RST_CYC) begin failures++; $display("FAIL to_pulse_width: got %0d..%0d want %0d", hmin, hmax, RST_CYC); end
        tests++; if (lmin !== TIMEOUT || lmax !== TIMEOUT) begin failures++; $display("FAIL to_wait_width: got %0d..%0d want %0d", lmin, lmax, TIMEOUT); end
        repeat (5) step();
        tests++; if ({fault, req_ready, busy, pll_reset, locked} !== 5'b11000) begin failures++; $display("FAIL to_fault_state: got %b want 11000", {fault, req_ready, busy, pll_reset, locked}); end
        tests++; if (got_codes !== exp_codes) begin failures++; $display("FAIL to_codes_kept: got %h want %h", got_codes, exp_codes); end
        rnd = 18'($urandom);
        issue_request(rnd[17:12], rnd[11:6], rnd[5:0]);
        tests++; if ({fault, pll_reset, got_codes} !== {2'b01, exp_codes}) begin failures++; $display("FAIL to_fault_clear: got %b/%b/%h want 0/1/%h", fault, pll_reset, got_codes, exp_codes); end
        count_high(n);
        settle_lock(int'($urandom_range(1, 600)), k, stray);
        tests++; if (k !== exp_lock_latency() || stray) begin failures++; $display("FAIL to_recover_lock: got %0d stray %b want %0d stray 0", k, stray, exp_lock_latency()); end
    endtask

    task automatic test_async_reset();
        int n, k;
        bit stray;
        logic [17:0] rnd;
        rnd = 18'($urandom);
        issue_request(rnd[17:12], rnd[11:6], rnd[5:0]);
        count_high(n);
        repeat (50) step();
        tests++; if ({busy, pll_reset} !== 2'b10) begin failures++; $display("FAIL ar_in_wait: got %b want 10", {busy, pll_reset}); end
        #3 reset_n = 1'b0;
        #1;
        exp_codes = {ID_INIT, FB_INIT, OD_INIT};
        tests++; if ({pll_reset, locked, busy, fault, req_ready} !== 5'b10100) begin failures++; $display("FAIL ar_flags: got %b want 10100", {pll_reset, locked, busy, fault, req_ready}); end
        tests++; if (got_codes !== exp_codes) begin failures++; $display("FAIL ar_codes: got %h want %h", got_codes, exp_codes); end
        repeat (2) step();
        #3 reset_n = 1'b1;
        count_high(n);
        tests++; if (n !== RST_CYC) begin failures++; $display("FAIL ar_pulse_width: got %0d want %0d", n, RST_CYC); end
        settle_lock(int'($urandom_range(1, 600)), k, stray);
        tests++; if (k !== exp_lock_latency() || stray) begin failures++; $display("FAIL ar_relock: got %0d stray %b want %0d stray 0", k, stray, exp_lock_latency()); end
    endtask

    initial begin
        test_reset();
        test_request();
        test_glitch();
        test_lock_loss();
        test_coincident();
        test_timeout();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/gw2a_rpll_ctrl.md
# gw2a_rpll_ctrl

Run-time controller for the GW2A rPLL in dynamic-divider mode: it drives the PLL's RESET and IDSEL/FBDSEL/ODSEL pins, sequences reset, and qualifies lock. It also retries on lock timeout and relocks automatically after lock loss. It sits between the board reference clock and the PLL wrapper, and gives the DDR3 clock/reset logic a debounced `locked` flag.

## Interface
Parameters:
- IDSEL_INIT, 6'h37, power-up IDSEL code, in rPLL pin encoding (not re-encoded here)
- FBDSEL_INIT, 6'h18, power-up FBDSEL code, pin encoding
- ODSEL_INIT, 6'h3C, power-up ODSEL code, pin encoding
- RESET_CYCLES, 16, width of the pll_reset pulse in clocks (>=1)
- SETTLE_CYCLES, 64, consecutive synced-lock-high clocks required before `locked` (>=1)
- LOCK_TIMEOUT, 4096, clocks allowed from pll_reset deassertion to `locked`
- RETRIES, 3, failed attempts allowed before `fault` (>=1)

Ports:
- clock  in  1  free-running reference clock (PLL input clock, never a PLL output)
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  new divider set offered
- req_ready  out  1  request accepted when valid&ready
- req_idsel / req_fbdsel / req_odsel  in  6 each  requested codes
- pll_lock  in  1  raw rPLL LOCK (asynchronous to clock)
- pll_reset  out  1  to rPLL RESET
- pll_idsel / pll_fbdsel / pll_odsel  out  6 each  to rPLL IDSEL/FBDSEL/ODSEL
- locked  out  1  qualified lock
- busy  out  1  sequence in progress
- fault  out  1  sticky; RETRIES attempts failed

## Operation
- pll_lock passes through a 2-FF synchroniser (lock_s) before any use.
- States: ASSERT, WAIT, SETTLE, LOCKED, FAULT.
- ASSERT:
  - pll_reset=1; rst_cnt counts to RESET_CYCLES.
  - Then go to WAIT with pll_reset=0, clear to_cnt.
- WAIT:
  - to_cnt++ each cycle.
  - lock_s=1: go to SETTLE with set_cnt=1.
  - to_cnt reaches LOCK_TIMEOUT: attempt fails.
- SETTLE:
  - to_cnt keeps counting.
  - lock_s=1: set_cnt++; when set_cnt reaches SETTLE_CYCLES, go to LOCKED.
  - lock_s=0: return to WAIT; set_cnt is reset, to_cnt is not.
  - Timeout applies here too.
- Attempt fail: att_cnt++. If att_cnt<RETRIES, go to ASSERT. Otherwise go to FAULT.
- LOCKED:
  - locked=1, req_ready=1.
  - lock_s=0: go to ASSERT, locked=0, att_cnt=0.
- FAULT:
  - fault=1, req_ready=1, pll_reset=0.
  - Stays here until a request is accepted.
- Request accept (valid&ready in LOCKED or FAULT):
  - Load req_* into pll_*sel, clear fault, att_cnt=0, locked=0.
  - Go to ASSERT.
  - Codes change only on this edge, so they are stable for the whole sequence.
- Accept and lock loss in the same cycle: the request wins. New codes are loaded and ASSERT is entered once.
- Retries reuse the current codes.
- busy = state in {ASSERT, WAIT, SETTLE}.
- Counter widths are $clog2 of their limit plus 1. Counters saturate and never wrap.

## Timing
- Reset values (during reset_n=0):
  - state=ASSERT, pll_reset=1, pll_*sel=*_INIT.
  - locked=0, busy=1, fault=0, req_ready=0.
  - All counters 0.
- After reset_n rises: pll_reset stays high for RESET_CYCLES clocks.
- After request accept at edge N:
  - Edge N+1: pll_*sel=new codes, pll_reset=1, locked=0, req_ready=0.
  - pll_reset falls at edge N+1+RESET_CYCLES.
- lock_s lags pll_lock by 2 clocks.
- locked rises on the edge after the SETTLE_CYCLES-th consecutive lock_s=1 cycle.
- Lock loss: locked falls 1 clock after lock_s falls (3 clocks after pll_lock falls), and pll_reset rises on the same edge.
- Worst-case fault latency: RETRIES*(RESET_CYCLES+LOCK_TIMEOUT) clocks, plus small per-transition overhead.
- Mid-sequence reset_n assertion: async return to reset values immediately; the sequence restarts from ASSERT.

## Structure
- Shared package/include gw2a_pll_pkg holds:
  - state encoding localparams;
  - the default *_INIT codes (27 MHz in, 120 MHz out) for reuse by the PLL wrapper.
- One sub-module: sync_ff (2-stage synchroniser, parameterised width), used for pll_lock.
- FSM and counters are inline in gw2a_rpll_ctrl.

## Test plan
- Reset release, model locks 100 clocks after pll_reset falls -> pll_reset high exactly 16 clocks; locked after 64 more qualified clocks; pll_*sel=INIT values throughout.
- In LOCKED, request {0x3A,0x10,0x3E} -> req_ready drops next cycle; pll_*sel update on the same edge pll_reset rises; locked re-asserts after relock.
- Model never locks -> exactly 3 pll_reset pulses, each followed by 4096 WAIT clocks; then fault=1, req_ready=1, busy=0; a new request clears fault.
- Lock glitches low for 1 clock at set_cnt=40 -> SETTLE restarts; locked only after 64 consecutive high clocks; no extra pll_reset pulse.
- In LOCKED, pll_lock drops -> locked=0 after 3 clocks, new 16-clock pll_reset pulse, att_cnt reset; also cover lock drop coincident with req_valid -> single ASSERT entered with the new codes.
- reset_n asserted during WAIT -> all outputs at reset values asynchronously; full sequence restarts after release.
